disp_scan_mux: RTL

- Time-multiplexed driver for a bank of NUM_DIGITS seven-segment digits sharing one segment bus.
- Generalises the two-digit action/speed select: the digit select is generated internally by a refresh prescaler instead of an external seletor.
- Adds per-digit enable, per-digit blink, anti-ghost blanking and selectable output polarity.
- Sits between the per-digit decoders (dec_7seg_* outputs, concatenated) and the board segment/anode pins.

---
 rtl/disp_scan_mux.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/disp_scan_mux.sv
// disp_scan_mux
//   Time-multiplexed driver for NUM_DIGITS seven-segment digits on one shared segment bus.
//   A refresh prescaler steps through the enabled digits in turn. Each slot ends with one
//   blank cycle so the old segments never show on the new digit. Digits can be disabled
//   or made to blink, and the polarity of the segment and digit pins is set by parameters.
//
// Ports
//   i_clk         system clock
//   i_rst         synchronous active-high reset
//   i_scan_en     1 = prescaler, scan index and blink state advance; 0 = all of them hold
//   i_seg_in      decoded patterns, active-high; digit i = [7i+6:7i], order {G,F,E,D,C,B,A}
//   i_digit_en    per-digit enable; a disabled digit is skipped by the scan
//   i_blink_mask  per-digit blink; a masked digit is dark while the blink phase is set
//   o_seg         segment bus {G..A}; polarity set by SEG_ACTIVE_LOW
//   o_dig         one-hot digit select; polarity set by DIG_ACTIVE_LOW
//   o_cur_idx     scan index registered alongside o_seg/o_dig
//   o_scan_tick   one-cycle pulse, registered, at each slot boundary

module disp_scan_mux #(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLINK_DIV      = 64,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1,
    localparam int unsigned IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_scan_en,
    input  logic [7*NUM_DIGITS-1:0] i_seg_in,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    input  logic [NUM_DIGITS-1:0]   i_blink_mask,
    output logic [6:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_dig,
    output logic [IDX_W-1:0]        o_cur_idx,
    output logic                    o_scan_tick
);

    localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    // All-off pin levels. XOR with these turns an active-high pattern into pin polarity.
    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                               : {NUM_DIGITS{1'b0}};

    logic [PRESC_W-1:0]    r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [BLINK_W-1:0]    r_blink_cnt;
    logic                  r_blink_phase;
    logic                  r_scan_tick;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig;
    logic [IDX_W-1:0]      r_cur_idx;

    logic                  w_tick;
    logic [NUM_DIGITS-1:0] w_dig_sel;
    logic [6:0]            w_seg_sel;
    logic                  w_en_cur;
    logic                  w_blink_cur;
    logic                  w_blank;
    logic [IDX_W-1:0]      w_idx_next;
    int unsigned           w_dist;
    int unsigned           w_best;

    assign w_tick = i_scan_en && (r_presc == PRESC_LAST);

    // Decode the current index once; the one-hot is reused to pick the segment slice and
    // the enable/blink bits, so no variable-width indexing is needed.
    always_comb begin
        w_dig_sel = '0;
        w_seg_sel = 7'h00;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_dig_sel[i] = 1'b1;
                w_seg_sel    = i_seg_in[7*i +: 7];
            end
        end
    end

    assign w_en_cur    = |(w_dig_sel & i_digit_en);
    assign w_blink_cur = |(w_dig_sel & i_blink_mask);

    // Blank on the slot boundary (anti-ghost), on a disabled current digit (this also
    // covers "no digit enabled") and on the dark half of a blinking digit.
    assign w_blank = w_tick || !w_en_cur || (w_blink_cur && r_blink_phase);

    // Next enabled digit after r_idx, searched circularly. The candidate with the smallest
    // non-zero forward distance wins; if none exists r_idx is kept.
    always_comb begin
        w_idx_next = r_idx;
        w_best     = NUM_DIGITS;
        w_dist     = 0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if (j >= 32'(r_idx)) begin
                w_dist = j - 32'(r_idx);
            end else begin
                w_dist = j + NUM_DIGITS - 32'(r_idx);
            end
            if (i_digit_en[j] && (w_dist != 0) && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_idx_next = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_scan_tick   <= 1'b0;
            r_seg         <= SEG_OFF;
            r_dig         <= DIG_OFF;
            r_cur_idx     <= '0;
        end else begin
            r_scan_tick <= w_tick;
            if (i_scan_en) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end
            if (w_tick) begin
                r_idx <= w_idx_next;
                if (r_blink_cnt == BLINK_LAST) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
            // Output stage reloads every cycle from the pre-update index, so the pins
            // trail the scan state by exactly one cycle.
            r_seg     <= (w_blank ? 7'h00 : w_seg_sel) ^ SEG_OFF;
            r_dig     <= (w_blank ? {NUM_DIGITS{1'b0}} : w_dig_sel) ^ DIG_OFF;
            r_cur_idx <= r_idx;
        end
    end

    assign o_seg       = r_seg;
    assign o_dig       = r_dig;
    assign o_cur_idx   = r_cur_idx;
    assign o_scan_tick = r_scan_tick;

endmodule
